// File: rtl/cache_drive_sync_bridge.sv
// rtl/cache_drive_sync_bridge.sv - async drive capture, sync and round-robin handoff to the cache datapath
module cache_drive_sync_bridge #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int FREE_PULSE_CYC = 2,
    localparam int CW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] i_drive,
    output logic [NUM_CH-1:0] o_free,
    output logic              o_req_valid,
    output logic [CW-1:0]     o_req_ch,
    input  logic              i_req_ready,
    input  logic              i_done,
    output logic              o_busy,
    output logic [NUM_CH-1:0] o_overrun
);
    localparam int FW = (FREE_PULSE_CYC > 1) ? $clog2(FREE_PULSE_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FREE
    } state_t;

    state_t                              state, state_nx;
    logic [CW-1:0]                       ch, ch_nx, rr, grant_ch, idx_c;
    logic [FW-1:0]                       cnt, cnt_nx;
    logic                                grant_ok;
    int                                  idx;
    logic [NUM_CH-1:0]                   pend_raw, ovr_raw, clr_q, clr_n;
    logic [NUM_CH-1:0]                   pend_s, served, eligible;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0]  pend_sync, ovr_sync;

    assign clr_n = {NUM_CH{rstn}} & ~clr_q;

    // Drive pulses may be shorter than a clk period, so each one clocks its own capture flop.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_cap
        logic pend_q, ovr_q;
        always_ff @(posedge i_drive[k] or negedge clr_n[k]) begin
            if (!clr_n[k]) pend_q <= 1'b0;
            else           pend_q <= 1'b1;
        end
        always_ff @(posedge i_drive[k] or negedge rstn) begin
            if (!rstn)          ovr_q <= 1'b0;
            else if (pend_q)    ovr_q <= 1'b1;
        end
        assign pend_raw[k] = pend_q;
        assign ovr_raw[k]  = ovr_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_sync <= '0;
            ovr_sync  <= '0;
        end else begin
            pend_sync <= {pend_sync[SYNC_STAGES-2:0], pend_raw};
            ovr_sync  <= {ovr_sync[SYNC_STAGES-2:0], ovr_raw};
        end
    end

    assign pend_s    = pend_sync[SYNC_STAGES-1];
    assign o_overrun = ovr_sync[SYNC_STAGES-1];
    assign o_req_ch  = ch;

    always_comb begin
        eligible = pend_s & ~served;
        grant_ok = 1'b0;
        grant_ch = '0;
        idx      = 0;
        idx_c    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx   = (int'(rr) + i) % NUM_CH;
            idx_c = CW'(idx);
            if (!grant_ok && eligible[idx_c]) begin
                grant_ok = 1'b1;
                grant_ch = idx_c;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: if (grant_ok) begin
                state_nx = ST_REQ;
                ch_nx    = grant_ch;
            end
            ST_REQ:  if (i_req_ready) state_nx = ST_WAIT;
            ST_WAIT: if (i_done) begin
                state_nx = ST_FREE;
                cnt_nx   = '0;
            end
            ST_FREE: begin
                if (cnt == FW'(FREE_PULSE_CYC - 1)) state_nx = ST_IDLE;
                else                                cnt_nx   = cnt + 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they toggle cleanly with the state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            ch          <= '0;
            cnt         <= '0;
            rr          <= '0;
            o_req_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_free      <= '0;
            clr_q       <= '0;
        end else begin
            state       <= state_nx;
            ch          <= ch_nx;
            cnt         <= cnt_nx;
            o_req_valid <= (state_nx == ST_REQ);
            o_busy      <= (state_nx != ST_IDLE);
            o_free      <= (state_nx == ST_FREE) ? (NUM_CH'(1) << ch_nx) : '0;
            clr_q       <= (state == ST_WAIT && i_done) ? (NUM_CH'(1) << ch) : '0;
            if (state == ST_REQ && i_req_ready) rr <= ch;
        end
    end

    // A freed branch stays masked until its synchronised flag has dropped, blocking a stale re-grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            served <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (state == ST_FREE && state_nx == ST_IDLE && ch == CW'(k)) served[k] <= 1'b1;
                else if (!pend_s[k])                                        served[k] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cache_drive_sync_bridge.sv
// tb/tb_cache_drive_sync_bridge.sv - randomized self-checking bench for cache_drive_sync_bridge
module tb_cache_drive_sync_bridge;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] drive = '0;
    logic [N-1:0] free;
    logic         req_valid;
    logic [1:0]   req_ch;
    logic         req_ready = 1'b0;
    logic         done = 1'b0;
    logic         busy;
    logic [N-1:0] overrun;

    int           checks = 0;
    int           failures = 0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_ovr = '0;
    int           m_rr = 0;

    cache_drive_sync_bridge #(.NUM_CH(N), .SYNC_STAGES(2), .FREE_PULSE_CYC(2)) dut (
        .clk(clk), .rstn(rstn), .i_drive(drive), .o_free(free),
        .o_req_valid(req_valid), .o_req_ch(req_ch), .i_req_ready(req_ready),
        .i_done(done), .o_busy(busy), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        drive = m;
        #3;
        drive = '0;
    endtask

    // Reference arbitration: first pending branch after the last accepted one.
    function automatic int predict();
        for (int i = 1; i <= N; i++) begin
            if (m_pend[(m_rr + i) % N]) return (m_rr + i) % N;
        end
        return -1;
    endfunction

    task automatic serve(input int exp_ch, input int rdy_dly, input int done_dly,
                         input bit inject, output int lat);
        int   n;
        bit   stable;
        logic [N-1:0] others;
        int   start;
        n = 0;
        while (!req_valid && n < 30) begin
            step();
            n++;
        end
        lat = n;
        check_eq("req_seen", req_valid, 1);
        check_eq("req_ch", req_ch, exp_ch);
        stable = 1'b1;
        repeat (rdy_dly) begin
            step();
            if (!req_valid || req_ch != exp_ch[1:0]) stable = 1'b0;
        end
        check_eq("req_hold", stable, 1);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        check_eq("valid_after_accept", req_valid, 0);
        check_eq("busy_wait", busy, 1);
        m_rr = exp_ch;
        m_pend[exp_ch] = 1'b0;
        if (inject) begin
            others = m_pend;
            start  = $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) begin
                if (others[(start + i) % N]) begin
                    pulse(N'(1) << ((start + i) % N));
                    m_ovr[(start + i) % N] = 1'b1;
                    break;
                end
            end
        end
        repeat (done_dly) step();
        check_eq("no_early_free", free, 0);
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq("free_1st", free, 32'(1) << exp_ch);
        step();
        check_eq("free_2nd", free, 32'(1) << exp_ch);
        step();
        check_eq("free_end", free, 0);
    endtask

    task automatic settle_idle(input string tag);
        bit quiet;
        quiet = 1'b1;
        repeat (10) begin
            step();
            if (req_valid || busy || free != '0) quiet = 1'b0;
        end
        check_eq(tag, quiet, 1);
        check_eq("overrun", overrun, m_ovr);
    endtask

    initial begin
        int lat;
        int c;
        logic [N-1:0] mask;
        bit   quiet;

        // Reset with drive toggling
        repeat (4) begin
            drive = 4'hF;
            #3;
            drive = 4'h0;
            #4;
        end
        step();
        check_eq("rst_outputs", {free, req_valid, req_ch, busy, overrun}, 0);
        rstn = 1'b1;
        settle_idle("rst_no_req");

        // Simultaneous edges, rr=0 -> 1,3,0
        pulse(4'b1011);
        m_pend = 4'b1011;
        serve(1, 0, 2, 1'b0, lat);
        serve(3, 1, 1, 1'b0, lat);
        serve(0, 0, 0, 1'b0, lat);
        settle_idle("simul_idle");

        // Single short pulse, latency bound
        pulse(4'b0100);
        m_pend = 4'b0100;
        serve(2, 0, 5, 1'b0, lat);
        check_eq("latency", lat <= 4, 1);
        settle_idle("single_idle");

        // Backpressure
        pulse(4'b0001);
        m_pend = 4'b0001;
        serve(0, 10, 3, 1'b0, lat);
        settle_idle("bp_idle");

        // Double edge on ch1 before its free
        pulse(4'b0010);
        #2;
        pulse(4'b0010);
        m_pend = 4'b0010;
        m_ovr[1] = 1'b1;
        serve(1, 2, 2, 1'b0, lat);
        settle_idle("ovr_single_req");

        // Randomized rounds
        for (int r = 0; r < 12; r++) begin
            mask = N'($urandom_range(1, 15));
            pulse(mask);
            m_pend = mask;
            while (m_pend != '0) begin
                c = predict();
                serve(c, $urandom_range(0, 3), $urandom_range(0, 5),
                      $urandom_range(0, 2) == 0, lat);
            end
            settle_idle("rand_idle");
        end

        // Reset while waiting on ch3
        pulse(4'b1000);
        m_pend = 4'b1000;
        lat = 0;
        while (!req_valid && lat < 30) begin
            step();
            lat++;
        end
        check_eq("rst6_req_ch", req_ch, 3);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        step();
        check_eq("rst6_busy_wait", busy, 1);
        rstn = 1'b0;
        #1;
        check_eq("rst6_busy_async", busy, 0);
        step();
        check_eq("rst6_busy_next", busy, 0);
        rstn = 1'b1;
        m_pend = '0;
        m_ovr  = '0;
        m_rr   = 0;
        done = 1'b1;
        step();
        done = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            step();
            if (free != '0 || req_valid) quiet = 1'b0;
        end
        check_eq("rst6_no_free", quiet, 1);
        check_eq("rst6_overrun", overrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
